// File: rtl/commit_arbiter.sv
// rtl/commit_arbiter.sv - in-order round-robin commit arbiter; optional watchdog via COMMIT_ARB_WATCHDOG_EN
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 4
`endif

module commit_arbiter #(
    parameter int n_lanes     = 4,
    parameter int data_width  = 16,
    parameter int n_blocks    = 256,
    parameter int full_width  = 2*data_width+8,
    parameter int stall_limit = 255
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic [n_lanes-1:0]                    in_valid,
    output logic [n_lanes-1:0]                    in_ready,
    input  logic [n_lanes*$clog2(n_blocks)-1:0]   block_in,
    input  logic [n_lanes*full_width-1:0]         result_in,
    input  logic [n_lanes*4-1:0]                  dest_in,
    input  logic [n_lanes*`COMMIT_ID_WIDTH-1:0]   commit_id_in,
    input  logic [n_lanes-1:0]                    commit_flag_in,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [$clog2(n_blocks)-1:0]           block_out,
    output logic signed [full_width-1:0]          result_out,
    output logic [3:0]                            dest_out,
    output logic [`COMMIT_ID_WIDTH-1:0]           commit_id_out,
    output logic                                  commit_flag_out,
    output logic [`COMMIT_ID_WIDTH-1:0]           expected_id,
    output logic                                  stall_err
);
    localparam int bw = $clog2(n_blocks);
    localparam int cw = `COMMIT_ID_WIDTH;
    localparam int lw = $clog2(n_lanes);

    logic [n_lanes-1:0] eligible;
    logic [lw-1:0]      rr;
    logic [lw-1:0]      winner;
    logic               found;
    logic               slot_free;
    logic               grant;

    for (genvar i = 0; i < n_lanes; i++) begin : g_elig
        assign eligible[i] = in_valid[i] && (commit_id_in[i*cw +: cw] == expected_id);
    end

    // Round-robin scan starting at rr; first eligible lane wins.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < n_lanes; k++) begin
            idx = (int'(rr) + k) % n_lanes;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = lw'(idx);
            end
        end
    end

    assign slot_free = !out_valid || out_ready;
    assign grant     = enable && slot_free && found;
    assign in_ready  = grant ? (n_lanes'(1) << winner) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid       <= 1'b0;
            block_out       <= '0;
            result_out      <= '0;
            dest_out        <= '0;
            commit_id_out   <= '0;
            commit_flag_out <= 1'b0;
            expected_id     <= '0;
            rr              <= '0;
        end else if (grant) begin
            out_valid       <= 1'b1;
            block_out       <= block_in[int'(winner)*bw +: bw];
            result_out      <= result_in[int'(winner)*full_width +: full_width];
            dest_out        <= dest_in[int'(winner)*4 +: 4];
            commit_id_out   <= commit_id_in[int'(winner)*cw +: cw];
            commit_flag_out <= commit_flag_in[winner];
            rr              <= (int'(winner) == n_lanes-1) ? '0 : winner + 1'b1;
            if (commit_flag_in[winner])
                expected_id <= expected_id + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef COMMIT_ARB_WATCHDOG_EN
    localparam int sw = $clog2(stall_limit+1);
    logic [sw-1:0] stall_cnt;
    logic          stall_cond;

    assign stall_cond = enable && (|in_valid) && !grant && slot_free;

    // Counter saturates at stall_limit; the error flag stays set until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else if (grant) begin
            stall_cnt <= '0;
        end else if (stall_cond && stall_cnt != sw'(stall_limit)) begin
            stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == sw'(stall_limit-1))
                stall_err <= 1'b1;
        end
    end
`else
    assign stall_err = 1'b0;
`endif

endmodule
